// File: rtl/frame_buffer_writer.sv
// Avalon-MM burst-write master that packs a 32-bit pixel stream two per word
// and fills one frame of the SDRAM frame buffer in fixed-length bursts.
module frame_buffer_writer #(
    parameter logic [29:0] ADDRESS      = 30'h3800_0000,
    parameter int          LENGTH       = 800*480*4,
    parameter int          BURST_LENGTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        frame_start,
    input  logic [31:0] pixel,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    output logic [28:0] address,
    output logic [7:0]  burstcount,
    output logic        write,
    output logic [63:0] writedata,
    output logic [7:0]  byteenable,
    input  logic        waitrequest,
    output logic        busy,
    output logic        frame_done
);

    localparam int PIX_TOTAL  = LENGTH / 4;
    localparam int WORD_TOTAL = LENGTH / 8;
    localparam int DEPTH      = 2 * BURST_LENGTH;
    localparam int AW         = $clog2(DEPTH);
    localparam int CW         = $clog2(DEPTH + 1);
    localparam int PW         = $clog2(PIX_TOTAL + 1);
    localparam int WW         = $clog2(WORD_TOTAL + 1);
    localparam logic [28:0] BASE = 29'(ADDRESS >> 3);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_BURST,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     half_q, half_d;
    logic            half_vld_q, half_vld_d;
    logic [AW-1:0]   wptr_q, wptr_d;
    logic [AW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   pix_q, pix_d;
    logic [WW-1:0]   word_q, word_d;
    logic [7:0]      beat_q, beat_d;
    logic [28:0]     addr_q, addr_d;
    logic [63:0]     mem_q [DEPTH];

    logic fifo_full;
    logic accept;
    logic push;
    logic pop;

    assign fifo_full   = (cnt_q == CW'(DEPTH));
    assign busy        = (state_q == S_FILL) || (state_q == S_BURST);
    // A full FIFO can still take one pixel into the empty half register.
    assign pixel_ready = busy && (pix_q < PW'(PIX_TOTAL))
                         && (!fifo_full || !half_vld_q);
    assign accept      = pixel_valid && pixel_ready;
    assign push        = accept && half_vld_q;
    assign write       = (state_q == S_BURST);
    assign pop         = write && !waitrequest;
    assign writedata   = write ? mem_q[rptr_q] : '0;
    assign address     = addr_q;
    assign burstcount  = 8'(BURST_LENGTH);
    assign byteenable  = 8'hFF;
    assign frame_done  = (state_q == S_DONE);

    // Next-state logic for the burst FSM, packer, FIFO pointers and counters.
    always_comb begin
        state_d    = state_q;
        half_d     = half_q;
        half_vld_d = half_vld_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        pix_d      = pix_q;
        word_d     = word_q;
        beat_d     = beat_q;
        addr_d     = addr_q;

        if (accept) begin
            pix_d = pix_q + PW'(1);
            if (half_vld_q) begin
                half_vld_d = 1'b0;
            end else begin
                half_d     = pixel;
                half_vld_d = 1'b1;
            end
        end
        if (push) begin
            wptr_d = (wptr_q == AW'(DEPTH - 1)) ? '0 : wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = (rptr_q == AW'(DEPTH - 1)) ? '0 : rptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d    = S_FILL;
                    addr_d     = BASE;
                    pix_d      = '0;
                    word_d     = '0;
                    beat_d     = '0;
                    half_vld_d = 1'b0;
                    wptr_d     = '0;
                    rptr_d     = '0;
                    cnt_d      = '0;
                end
            end
            S_FILL: begin
                if (cnt_q >= CW'(BURST_LENGTH)) begin
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (pop) begin
                    if (beat_q == 8'(BURST_LENGTH - 1)) begin
                        beat_d  = '0;
                        addr_d  = addr_q + 29'(BURST_LENGTH);
                        word_d  = word_q + WW'(BURST_LENGTH);
                        state_d = (word_q + WW'(BURST_LENGTH) == WW'(WORD_TOTAL))
                                  ? S_DONE : S_FILL;
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            half_q     <= '0;
            half_vld_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            pix_q      <= '0;
            word_q     <= '0;
            beat_q     <= '0;
            addr_q     <= BASE;
        end else begin
            state_q    <= state_d;
            half_q     <= half_d;
            half_vld_q <= half_vld_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            pix_q      <= pix_d;
            word_q     <= word_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
        end
    end

    // FIFO storage; the first pixel of a pair lands in the low half.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wptr_q] <= {pixel, half_q};
        end
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Directed bench for frame_buffer_writer: small frame of 64 pixels,
// 8-beat bursts at word address 0x200.
module tb_frame_buffer_writer;

    localparam logic [29:0] ADDR = 30'h0000_1000;
    localparam int          LEN  = 256;
    localparam int          BL   = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        frame_start;
    logic [31:0] pixel;
    logic        pixel_valid;
    logic        pixel_ready;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        write;
    logic [63:0] writedata;
    logic [7:0]  byteenable;
    logic        waitrequest;
    logic        busy;
    logic        frame_done;

    frame_buffer_writer #(
        .ADDRESS      (ADDR),
        .LENGTH       (LEN),
        .BURST_LENGTH (BL)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .frame_start (frame_start),
        .pixel       (pixel),
        .pixel_valid (pixel_valid),
        .pixel_ready (pixel_ready),
        .address     (address),
        .burstcount  (burstcount),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clock = ~clock;

    int n_chk = 0;
    int n_fail = 0;

    int pix_next, pix_limit, acc, mode, ov_err;
    bit en_pix;
    logic [63:0] bd[$];
    logic [28:0] ba[$];
    int bcyc[$];
    int bc_err, hold_err, done_cnt, cyc, done_cyc;
    logic busy_at_done;
    bit held;
    logic [28:0] h_a;
    logic [63:0] h_d;
    logic [7:0]  h_bc;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        pix_next = 0;
        acc      = 0;
        ov_err   = 0;
        bd.delete();
        ba.delete();
        bcyc.delete();
        bc_err   = 0;
        hold_err = 0;
        done_cnt = 0;
        held     = 1'b0;
        cyc      = 0;
        done_cyc = 0;
    endtask

    task automatic cycle();
        @(negedge clock);
        cyc++;
        if (!reset) begin
            if (held && write) begin
                if (address !== h_a || writedata !== h_d || burstcount !== h_bc)
                    hold_err++;
            end
            held = write && waitrequest;
            h_a  = address;
            h_d  = writedata;
            h_bc = burstcount;
            if (write && !waitrequest) begin
                bd.push_back(writedata);
                ba.push_back(address);
                bcyc.push_back(cyc);
                if (burstcount !== 8'd8) bc_err++;
            end
            if (pixel_valid && pixel_ready) begin
                if (acc >= 64) ov_err++;
                acc++;
                pix_next++;
            end
            if (frame_done) begin
                done_cnt++;
                busy_at_done = busy;
                done_cyc = cyc;
            end
        end
        @(posedge clock);
        #1;
        pixel_valid = en_pix && (pix_next < pix_limit);
        pixel = 32'(pix_next);
        case (mode)
            0: waitrequest = 1'b0;
            1: waitrequest = ~waitrequest;
            2: waitrequest = (bd.size() >= 1);
            default: waitrequest = 1'b1;
        endcase
    endtask

    task automatic start_pulse();
        frame_start = 1'b1;
        cycle();
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int budget);
        int k;
        k = 0;
        while (done_cnt == 0 && k < budget) begin
            cycle();
            k++;
        end
        repeat (3) cycle();
        chk("frame_done_count", 64'(done_cnt), 64'd1);
        chk("busy_at_done", {63'd0, busy_at_done}, 64'd0);
    endtask

    task automatic check_frame(input string tag);
        chk({tag, "_beats"}, 64'(bd.size()), 64'd32);
        for (int j = 0; j < bd.size() && j < 32; j++) begin
            chk({tag, "_addr"}, {35'd0, ba[j]}, 64'h200 + 64'(8 * (j / 8)));
            chk({tag, "_data"}, bd[j], {32'(2 * j + 1), 32'(2 * j)});
        end
        chk({tag, "_burstcount"}, 64'(bc_err), 64'd0);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        pixel_valid = 1'b0;
        pixel       = '0;
        waitrequest = 1'b0;
        en_pix      = 1'b0;
        pix_limit   = 64;
        mode        = 0;
        clear_mon();
        repeat (3) cycle();
        chk("rst_ready", {63'd0, pixel_ready}, 64'd0);
        chk("rst_write", {63'd0, write}, 64'd0);
        chk("rst_address", {35'd0, address}, 64'h200);
        chk("rst_writedata", writedata, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, frame_done}, 64'd0);
        reset = 1'b0;

        // pixels offered while idle
        en_pix = 1'b1;
        repeat (6) cycle();
        chk("idle_acc", 64'(acc), 64'd0);
        chk("idle_ready", {63'd0, pixel_ready}, 64'd0);
        chk("idle_write", {63'd0, write}, 64'd0);

        // basic frame, full rate
        start_pulse();
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        run_frame(600);
        check_frame("basic");
        if (bd.size() > 0)
            chk("first_beat", bd[0], 64'h00000001_00000000);
        if (bcyc.size() >= 8)
            chk("burst_len_cycles", 64'(bcyc[7] - bcyc[0]), 64'd7);
        if (bcyc.size() >= 32)
            chk("done_latency", 64'(done_cyc - bcyc[31]), 64'd1);
        chk("basic_acc", 64'(acc), 64'd64);

        // backpressure on alternate cycles
        clear_mon();
        mode = 1;
        start_pulse();
        run_frame(1000);
        check_frame("bp");
        chk("bp_hold", 64'(hold_err), 64'd0);
        mode = 0;

        // waitrequest stuck after first beat
        clear_mon();
        mode = 2;
        start_pulse();
        repeat (60) cycle();
        chk("fc_acc", 64'(acc), 64'd35);
        chk("fc_ready", {63'd0, pixel_ready}, 64'd0);
        chk("fc_beats", 64'(bd.size()), 64'd1);
        chk("fc_write", {63'd0, write}, 64'd1);
        mode = 0;
        run_frame(600);
        check_frame("fc");
        chk("fc_acc_total", 64'(acc), 64'd64);

        // overrun plus a frame_start during a burst
        clear_mon();
        pix_limit = 70;
        start_pulse();
        for (int k = 0; k < 300 && bd.size() < 10; k++) cycle();
        chk("ov_mid_write", {63'd0, write}, 64'd1);
        start_pulse();
        run_frame(600);
        check_frame("ov");
        chk("ov_acc", 64'(acc), 64'd64);
        chk("ov_ready_after_64", 64'(ov_err), 64'd0);
        pix_limit = 64;

        // reset in the middle of a burst
        clear_mon();
        start_pulse();
        for (int k = 0; k < 300 && bd.size() < 3; k++) cycle();
        chk("mid_write_before_rst", {63'd0, write}, 64'd1);
        reset = 1'b1;
        cycle();
        chk("mid_rst_write", {63'd0, write}, 64'd0);
        chk("mid_rst_address", {35'd0, address}, 64'h200);
        chk("mid_rst_writedata", writedata, 64'd0);
        chk("mid_rst_busy", {63'd0, busy}, 64'd0);
        chk("mid_rst_done", {63'd0, frame_done}, 64'd0);
        chk("mid_rst_ready", {63'd0, pixel_ready}, 64'd0);
        reset = 1'b0;
        cycle();
        clear_mon();
        start_pulse();
        run_frame(600);
        check_frame("restart");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
